// File: rtl/ghost_round_scheduler.sv
// Ghost round scheduler: drives the movement tick, the staggered per-ghost
// move enables, collision-to-lives resolution, the post-hit freeze window and
// the sticky fail/clear result for the play stage.
module ghost_round_scheduler #(
  parameter int N_GHOST      = 2,
  parameter int TICK_DIV     = 10_000_000,
  parameter int FREEZE_TICKS = 20,
  parameter int LIVES        = 3,
  parameter int PLAY_STATE   = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2:0]         stage_state,
  input  logic [N_GHOST-1:0] hit_vec,
  input  logic               goal_reached,
  output logic [N_GHOST-1:0] move_en,
  output logic               ghost_hold,
  output logic [1:0]         hit_id,
  output logic [1:0]         lives,
  output logic               fail,
  output logic               clear,
  output logic [2:0]         sched_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_FREEZE = 3'd2,
    S_OVER   = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  localparam int CW = $clog2(TICK_DIV);
  localparam int FW = (FREEZE_TICKS > 1) ? $clog2(FREEZE_TICKS) : 1;

  localparam logic [CW-1:0] TICK_LAST   = CW'(TICK_DIV - 1);
  localparam logic [FW-1:0] FREEZE_LAST = FW'(FREEZE_TICKS - 1);
  localparam logic [1:0]    LIVES_INIT  = 2'(LIVES);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [FW-1:0]      frz_q, frz_d;
  logic [N_GHOST-1:0] move_en_q, move_en_d;
  logic               ghost_hold_q, ghost_hold_d;
  logic [1:0]         hit_id_q, hit_id_d;
  logic [1:0]         lives_q, lives_d;
  logic               fail_q, fail_d;
  logic               clear_q, clear_d;

  logic       in_play;
  logic       counting;
  logic       tick;
  logic [1:0] hit_idx;

  assign in_play  = (stage_state == 3'(PLAY_STATE));
  assign counting = (state_q == S_RUN) || (state_q == S_FREEZE);
  assign tick     = counting && (cnt_q == TICK_LAST);

  // Lowest-index ghost wins when several report a hit in the same cycle.
  always_comb begin
    hit_idx = 2'd0;
    for (int i = N_GHOST - 1; i >= 0; i--) begin
      if (hit_vec[i]) hit_idx = 2'(i);
    end
  end

  // Next-state, counter and output computation for the scheduler FSM.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    cnt_d      = counting ? (tick ? '0 : cnt_q + CW'(1)) : '0;
    frz_d      = frz_q;
    hit_id_d   = hit_id_q;
    lives_d    = lives_q;
    fail_d     = fail_q;
    clear_d    = clear_q;
    move_en_d  = '0;

    unique case (state_q)
      S_IDLE: begin
        frz_d   = '0;
        lives_d = LIVES_INIT;
        if (in_play) state_d = S_RUN;
      end
      S_RUN: begin
        if (|hit_vec) begin
          hit_id_d = hit_idx;
          if (lives_q <= 2'd1) begin
            lives_d = 2'd0;
            fail_d  = 1'b1;
            state_d = S_OVER;
          end else begin
            lives_d = lives_q - 2'd1;
            frz_d   = '0;
            state_d = S_FREEZE;
          end
        end else if (goal_reached) begin
          clear_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_FREEZE: begin
        if (tick) begin
          if (frz_q == FREEZE_LAST) begin
            frz_d   = '0;
            state_d = S_RUN;
          end else begin
            frz_d = frz_q + FW'(1);
          end
        end
      end
      S_OVER, S_DONE: ;
      default: state_d = S_IDLE;
    endcase

    // Leaving the play stage discards everything, whatever the current state.
    if (!in_play) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      frz_d    = '0;
      hit_id_d = 2'd0;
      lives_d  = LIVES_INIT;
      fail_d   = 1'b0;
      clear_d  = 1'b0;
    end

    // Stagger chain: ghost 0 steps the cycle after a tick, ghost i one cycle
    // after ghost i-1. Any exit from RUN flushes the pending chain.
    if (state_d == S_RUN) begin
      move_en_d[0] = tick;
      for (int i = 1; i < N_GHOST; i++) move_en_d[i] = move_en_q[i-1];
    end

    ghost_hold_d = (state_d != S_RUN);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      frz_q        <= '0;
      move_en_q    <= '0;
      ghost_hold_q <= 1'b1;
      hit_id_q     <= 2'd0;
      lives_q      <= LIVES_INIT;
      fail_q       <= 1'b0;
      clear_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      frz_q        <= frz_d;
      move_en_q    <= move_en_d;
      ghost_hold_q <= ghost_hold_d;
      hit_id_q     <= hit_id_d;
      lives_q      <= lives_d;
      fail_q       <= fail_d;
      clear_q      <= clear_d;
    end
  end

  assign move_en     = move_en_q;
  assign ghost_hold  = ghost_hold_q;
  assign hit_id      = hit_id_q;
  assign lives       = lives_q;
  assign fail        = fail_q;
  assign clear       = clear_q;
  assign sched_state = state_q;

endmodule

// File: tb/tb_ghost_round_scheduler.sv
// Directed bench for ghost_round_scheduler with a short tick (8 cycles) and
// a two-tick freeze window.
module tb_ghost_round_scheduler;

  logic       clk;
  logic       rst_n;
  logic [2:0] stage_state;
  logic [1:0] hit_vec;
  logic       goal_reached;
  logic [1:0] move_en;
  logic       ghost_hold;
  logic [1:0] hit_id;
  logic [1:0] lives;
  logic       fail;
  logic       clear;
  logic [2:0] sched_state;

  int checks;
  int failures;

  ghost_round_scheduler #(
    .N_GHOST(2), .TICK_DIV(8), .FREEZE_TICKS(2), .LIVES(3), .PLAY_STATE(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stage_state(stage_state), .hit_vec(hit_vec),
    .goal_reached(goal_reached), .move_en(move_en), .ghost_hold(ghost_hold),
    .hit_id(hit_id), .lives(lives), .fail(fail), .clear(clear),
    .sched_state(sched_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock edge, then settle so outputs are sampled away from the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_for_state(input logic [2:0] s, input int max, output int n);
    n = 0;
    while (sched_state !== s && n < max) begin
      cyc();
      n++;
    end
  endtask

  task automatic enter_play();
    stage_state = 3'd3;
    cyc();
    stage_state = 3'd5;
    cyc();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stage_state = 3'd0; hit_vec = 2'b00; goal_reached = 1'b0;
    cyc();
    checks++;
    if ({sched_state, move_en, ghost_hold, hit_id, lives, fail, clear} !== {3'd0, 2'b00, 1'b1, 2'd0, 2'd3, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_values got st=%0d me=%b hold=%b id=%0d lives=%0d fail=%b clear=%b exp st=0 me=00 hold=1 id=0 lives=3 fail=0 clear=0",
               sched_state, move_en, ghost_hold, hit_id, lives, fail, clear);
    end
    rst_n = 1'b1;
    cyc();
    checks++;
    if (sched_state !== 3'd0) begin
      failures++;
      $display("FAIL idle_without_play got=%0d exp=0", sched_state);
    end
  endtask

  // Edge 1 enters RUN; ghost 0 steps at edges 9,17 and ghost 1 at 10,18.
  task automatic test_run_stagger(input string tag);
    logic [1:0] exp_me;
    stage_state = 3'd5;
    for (int e = 1; e <= 18; e++) begin
      cyc();
      exp_me = (e == 9 || e == 17) ? 2'b01 : (e == 10 || e == 18) ? 2'b10 : 2'b00;
      checks++;
      if ({sched_state, ghost_hold, move_en} !== {3'd1, 1'b0, exp_me}) begin
        failures++;
        $display("FAIL %s edge%0d got st=%0d hold=%b me=%b exp st=1 hold=0 me=%b",
                 tag, e, sched_state, ghost_hold, move_en, exp_me);
      end
    end
  endtask

  task automatic test_hit_freeze();
    int n;
    logic bad;
    hit_vec = 2'b10;
    cyc();
    hit_vec = 2'b00;
    checks++;
    if ({sched_state, hit_id, lives, ghost_hold} !== {3'd2, 2'd1, 2'd2, 1'b1}) begin
      failures++;
      $display("FAIL hit_enter got st=%0d id=%0d lives=%0d hold=%b exp st=2 id=1 lives=2 hold=1",
               sched_state, hit_id, lives, ghost_hold);
    end
    // Hits during FREEZE must be ignored; the window lasts until edge 33.
    n = 0; bad = 1'b0;
    while (sched_state === 3'd2 && n < 40) begin
      hit_vec = (n < 3) ? 2'b01 : 2'b00;
      cyc();
      n++;
      if (sched_state === 3'd2 && (move_en !== 2'b00 || ghost_hold !== 1'b1 || lives !== 2'd2 || hit_id !== 2'd1)) bad = 1'b1;
    end
    hit_vec = 2'b00;
    checks++;
    if (bad !== 1'b0) begin
      failures++;
      $display("FAIL freeze_quiet got=%b exp=0", bad);
    end
    checks++;
    if ({sched_state, ghost_hold} !== {3'd1, 1'b0} || n !== 14) begin
      failures++;
      $display("FAIL freeze_exit got st=%0d hold=%b cycles=%0d exp st=1 hold=0 cycles=14", sched_state, ghost_hold, n);
    end
  endtask

  task automatic test_lives_over();
    int n;
    enter_play();
    for (int k = 0; k < 3; k++) begin
      hit_vec = 2'b11;
      cyc();
      hit_vec = 2'b00;
      checks++;
      if ({lives, hit_id, sched_state} !== {2'(2 - k), 2'd0, (k < 2) ? 3'd2 : 3'd3}) begin
        failures++;
        $display("FAIL lives_hit%0d got lives=%0d id=%0d st=%0d exp lives=%0d id=0 st=%0d",
                 k, lives, hit_id, sched_state, 2 - k, (k < 2) ? 2 : 3);
      end
      if (k < 2) begin
        wait_for_state(3'd1, 40, n);
        checks++;
        if (sched_state !== 3'd1) begin
          failures++;
          $display("FAIL lives_rerun%0d got=%0d exp=1", k, sched_state);
        end
      end
    end
    hit_vec = 2'b11;
    repeat (3) cyc();
    hit_vec = 2'b00;
    checks++;
    if ({sched_state, lives, fail, ghost_hold, move_en} !== {3'd3, 2'd0, 1'b1, 1'b1, 2'b00}) begin
      failures++;
      $display("FAIL over_sticky got st=%0d lives=%0d fail=%b hold=%b me=%b exp st=3 lives=0 fail=1 hold=1 me=00",
               sched_state, lives, fail, ghost_hold, move_en);
    end
  endtask

  task automatic test_goal();
    int n;
    enter_play();
    goal_reached = 1'b1; hit_vec = 2'b01;
    cyc();
    goal_reached = 1'b0; hit_vec = 2'b00;
    checks++;
    if ({sched_state, lives, clear, hit_id} !== {3'd2, 2'd2, 1'b0, 2'd0}) begin
      failures++;
      $display("FAIL goal_vs_hit got st=%0d lives=%0d clear=%b id=%0d exp st=2 lives=2 clear=0 id=0",
               sched_state, lives, clear, hit_id);
    end
    wait_for_state(3'd1, 40, n);
    goal_reached = 1'b1;
    cyc();
    checks++;
    if ({sched_state, clear, ghost_hold} !== {3'd4, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL goal_done got st=%0d clear=%b hold=%b exp st=4 clear=1 hold=1", sched_state, clear, ghost_hold);
    end
    hit_vec = 2'b11;
    repeat (3) cyc();
    goal_reached = 1'b0; hit_vec = 2'b00;
    checks++;
    if ({sched_state, clear, lives, move_en} !== {3'd4, 1'b1, 2'd2, 2'b00}) begin
      failures++;
      $display("FAIL done_sticky got st=%0d clear=%b lives=%0d me=%b exp st=4 clear=1 lives=2 me=00",
               sched_state, clear, lives, move_en);
    end
  endtask

  task automatic test_abort();
    stage_state = 3'd3;
    cyc();
    checks++;
    if ({sched_state, clear} !== {3'd0, 1'b0}) begin
      failures++;
      $display("FAIL abort_done got st=%0d clear=%b exp st=0 clear=0", sched_state, clear);
    end
    stage_state = 3'd5;
    cyc();
    hit_vec = 2'b01;
    cyc();
    hit_vec = 2'b00;
    repeat (2) cyc();
    stage_state = 3'd3;
    cyc();
    checks++;
    if ({sched_state, lives, fail, clear, ghost_hold, move_en, hit_id} !== {3'd0, 2'd3, 1'b0, 1'b0, 1'b1, 2'b00, 2'd0}) begin
      failures++;
      $display("FAIL abort_freeze got st=%0d lives=%0d fail=%b clear=%b hold=%b me=%b id=%0d exp st=0 lives=3 fail=0 clear=0 hold=1 me=00 id=0",
               sched_state, lives, fail, clear, ghost_hold, move_en, hit_id);
    end
    test_run_stagger("restart");
  endtask

  task automatic test_async_reset();
    hit_vec = 2'b10;
    cyc();
    hit_vec = 2'b00;
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sched_state, lives, hit_id, ghost_hold, move_en} !== {3'd0, 2'd3, 2'd0, 1'b1, 2'b00}) begin
      failures++;
      $display("FAIL async_reset got st=%0d lives=%0d id=%0d hold=%b me=%b exp st=0 lives=3 id=0 hold=1 me=00",
               sched_state, lives, hit_id, ghost_hold, move_en);
    end
    #2;
    rst_n = 1'b1;
    cyc();
    checks++;
    if ({sched_state, ghost_hold} !== {3'd1, 1'b0}) begin
      failures++;
      $display("FAIL reset_rerun got st=%0d hold=%b exp st=1 hold=0", sched_state, ghost_hold);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_run_stagger("run");
    test_hit_freeze();
    test_lives_over();
    test_goal();
    test_abort();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
